// File: rtl/systolic_job_sched_pkg.sv
// Shared types for the systolic job scheduler: FSM encoding and 2x2 matrix
// views of the flat operand/result buses (element 00 sits at the MSB).
package systolic_sched_pkg;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] e00;
    logic [DATA_W-1:0] e01;
    logic [DATA_W-1:0] e10;
    logic [DATA_W-1:0] e11;
  } op_mat_t;

  typedef struct packed {
    logic [ACC_W-1:0] c00;
    logic [ACC_W-1:0] c01;
    logic [ACC_W-1:0] c10;
    logic [ACC_W-1:0] c11;
  } res_mat_t;

  function automatic op_mat_t unpack_op(input logic [4*DATA_W-1:0] v);
    return op_mat_t'(v);
  endfunction

  function automatic logic [4*DATA_W-1:0] pack_op(input op_mat_t m);
    return m;
  endfunction

  function automatic res_mat_t unpack_res(input logic [4*ACC_W-1:0] v);
    return res_mat_t'(v);
  endfunction

  function automatic logic [4*ACC_W-1:0] pack_res(input res_mat_t m);
    return m;
  endfunction

endpackage

// File: rtl/systolic_job_sched_if.sv
// Job request, response and array-side signals of the systolic scheduler.
// slave = scheduler view, master = requesters plus array.
interface systolic_job_sched_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9
);
  logic [1:0]                       req_valid;
  logic [1:0]                       req_ready;
  logic [1:0][4*DATA_WIDTH-1:0]     req_a;
  logic [1:0][4*DATA_WIDTH-1:0]     req_b;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic                             rsp_id;
  logic                             rsp_err;
  logic [4*ACC_WIDTH-1:0]           rsp_c;
  logic                             arr_in_valid;
  logic [4*DATA_WIDTH-1:0]          arr_a;
  logic [4*DATA_WIDTH-1:0]          arr_b;
  logic                             arr_out_valid;
  logic [4*ACC_WIDTH-1:0]           arr_c;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, arr_out_valid, arr_c,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_c, arr_in_valid, arr_a, arr_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, arr_out_valid, arr_c,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_c, arr_in_valid, arr_a, arr_b
  );
endinterface

// File: rtl/systolic_job_sched_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that did not win
// last time is picked. Pure combinational; the caller owns rr_last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = rr_last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/systolic_job_sched.sv
// Round-robin job scheduler in front of a 2x2 systolic multiply array, with a
// watchdog that turns a missing array out_valid into an error response.
module systolic_job_sched
  import systolic_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int FEED_CYCLES = 4,
  parameter int TIMEOUT     = 31
) (
  input  logic                  clk,
  input  logic                  rstn,
  systolic_job_sched_if.slave   bus,
  output logic                  busy
);

  localparam int FCW = $clog2(FEED_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic              rr_last_q;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              hs;
  logic [FCW-1:0]    feed_cnt_q;
  logic [TCW-1:0]    wd_cnt_q;
  logic              feed_last, wd_last;
  logic              sticky_q;
  logic              id_q, err_q;
  op_mat_t           a_q, b_q;
  res_mat_t          c_q;
  logic [4*DATA_WIDTH-1:0] a_sel, b_sel;
  logic [4*ACC_WIDTH-1:0]  c_in;

  rr_arbiter2 u_arb (
    .req     (bus.req_valid),
    .rr_last (rr_last_q),
    .gnt     (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign hs        = (state_q == IDLE) && (gnt != 2'b00);
  assign feed_last = (feed_cnt_q == FCW'(FEED_CYCLES - 1));
  assign wd_last   = (wd_cnt_q == TCW'(TIMEOUT - 1));
  assign a_sel     = bus.req_a[gnt_idx];
  assign b_sel     = bus.req_b[gnt_idx];
  assign c_in      = bus.arr_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (hs) state_d = ISSUE;
      ISSUE: if (feed_last) state_d = WAIT;
      WAIT:  if (sticky_q || bus.arr_out_valid || wd_last) state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rstn so nothing looks acceptable while held in reset
  always_comb begin
    busy             = (state_q != IDLE);
    bus.arr_in_valid = (state_q == ISSUE);
    bus.rsp_valid    = (state_q == RESP);
    bus.req_ready    = (state_q == IDLE && rstn) ? gnt : 2'b00;
  end

  assign bus.arr_a   = pack_op(a_q);
  assign bus.arr_b   = pack_op(b_q);
  assign bus.rsp_c   = pack_res(c_q);
  assign bus.rsp_id  = id_q;
  assign bus.rsp_err = err_q;

  // C is captured at most once per job; an early ISSUE pulse sets sticky_q so
  // WAIT uses the latched copy instead of a later, possibly stale arr_c.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last_q  <= 1'b1;
      feed_cnt_q <= '0;
      wd_cnt_q   <= '0;
      sticky_q   <= 1'b0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (hs) begin
          a_q        <= unpack_op(a_sel);
          b_q        <= unpack_op(b_sel);
          id_q       <= gnt_idx;
          rr_last_q  <= gnt_idx;
          feed_cnt_q <= '0;
          wd_cnt_q   <= '0;
          sticky_q   <= 1'b0;
        end
        ISSUE: begin
          feed_cnt_q <= feed_cnt_q + FCW'(1);
          if (bus.arr_out_valid && !sticky_q) begin
            sticky_q <= 1'b1;
            c_q      <= unpack_res(c_in);
          end
        end
        WAIT: begin
          wd_cnt_q <= wd_cnt_q + TCW'(1);
          if (sticky_q) begin
            err_q <= 1'b0;
          end else if (bus.arr_out_valid) begin
            c_q   <= unpack_res(c_in);
            err_q <= 1'b0;
          end else if (wd_last) begin
            c_q   <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/systolic_job_sched.md
Name: systolic_job_sched

Overview:
- Scheduler and arbiter in front of one 2x2 systolic multiply array (4-bit operands, 9-bit accumulators).
- Two independent requesters submit 2x2 matrix-multiply jobs over valid/ready.
- The block grants round-robin, holds the array's in_valid for a fixed feed window, waits for the array's out_valid, captures C, and returns it tagged with the requester id.
- A watchdog converts a missing out_valid into an error response, so the array can never deadlock a requester.

Parameters:
- DATA_WIDTH, 4, operand element width.
- ACC_WIDTH, 9, result element width (2*DATA_WIDTH+1).
- FEED_CYCLES, 4, cycles arr_in_valid is held high per job (range 1..15).
- TIMEOUT, 31, max cycles in WAIT before the error response (range 1..255).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester job valid (bit i = requester i)
- req_ready  out  2  per-requester job accept
- req_a  in  2*4*DATA_WIDTH  A matrices; requester i at slice i; element order a00,a01,a10,a11 from MSB
- req_b  in  2*4*DATA_WIDTH  B matrices, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester that owns the response
- rsp_err  out  1  1 = timeout; rsp_c forced to 0
- rsp_c  out  4*ACC_WIDTH  c00,c01,c10,c11 from MSB
- arr_in_valid  out  1  array in_valid
- arr_a  out  4*DATA_WIDTH  array A operands (held constant for the whole job)
- arr_b  out  4*DATA_WIDTH  array B operands
- arr_out_valid  in  1  array out_valid
- arr_c  in  4*ACC_WIDTH  array C outputs
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rstn low): FSM=IDLE, rr_last=1 (so requester 0 wins first), all counters 0. Outputs reset to 0: req_ready, rsp_valid, rsp_id, rsp_err, rsp_c, arr_in_valid, arr_a, arr_b, busy.
- Reset mid-job aborts the job silently; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Combinational grant: if both requesters are valid, pick the one that is not rr_last; otherwise pick the single valid one.
  - req_ready[g] is high combinationally only in IDLE for the granted index; the handshake occurs that cycle.
  - On handshake: register arr_a/arr_b from the granted slice, store id, set rr_last=g, clear counters, go to ISSUE.
- ISSUE:
  - arr_in_valid=1 for exactly FEED_CYCLES consecutive cycles, starting the cycle after acceptance.
  - Then go to WAIT; arr_in_valid drops to 0.
- WAIT:
  - arr_in_valid=0. The watchdog counts from 0 on entry.
  - arr_out_valid=1 (also accepted if it rises during ISSUE; it is latched via a sticky flag): capture arr_c into rsp_c, rsp_err=0, go to RESP.
  - Watchdog reaches TIMEOUT with no out_valid: rsp_c=0, rsp_err=1, go to RESP.
  - Latency from acceptance to rsp_valid = FEED_CYCLES + wait cycles + 1.
- RESP:
  - rsp_valid=1. rsp_id, rsp_err and rsp_c are stable until the cycle rsp_valid && rsp_ready.
  - Then go to IDLE.
  - arr_out_valid pulses in RESP or IDLE are ignored and do not set the sticky flag.
  - No new grant is possible until IDLE, so jobs never overlap.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. A single active requester is granted every job.
- Widths: no arithmetic on data; C is passed through unmodified. Counters are sized to clog2 of their parameter + 1.
- busy = (state != IDLE).

Decomposition:
- Package systolic_sched_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - packed struct for the 2x2 operand and result matrices
  - unpack/pack helper functions
- Sub-module rr_arbiter2: 2-requester round-robin; inputs are the request vector and rr_last, the output is a one-hot grant. It is purely combinational; the FSM owns rr_last.
- Everything else is in the top module.

Test Plan:
- Single job: requester 0 sends A=1,2,3,4 and B=5,6,7,8; the array model returns out_valid 3 cycles after the feed → rsp_c=19,22,43,50, rsp_id=0, rsp_err=0; arr_in_valid is high exactly 4 cycles.
- Contention: both requesters valid from reset with two jobs each → grant order 0,1,0,1; req_ready is never high for both bits in the same cycle.
- Backpressure: rsp_ready held low for 10 cycles → rsp_valid, rsp_c and rsp_id are stable; req_ready stays 0 throughout; the next job is accepted only in the cycle after the rsp handshake.
- Timeout: the array model never asserts out_valid → rsp_valid with rsp_err=1 and rsp_c=0 exactly FEED_CYCLES+TIMEOUT+1 cycles after acceptance; FSM returns to IDLE.
- Spurious and early out_valid:
  - A pulse in IDLE → no response.
  - A pulse during ISSUE → the response is produced right after ISSUE ends, using the latched C.
- Reset mid-WAIT: drop rstn → all outputs 0 immediately, busy=0; after release, requester 0 is granted first.
